hazard_ctl: RTL and testbench

- Pipeline interlock controller for the mips789 core. It sequences pipeline advance around the forwarding network.
- It detects hazards that forwarding cannot resolve: load-use, HI/LO access while the multi-cycle mul/div is busy, and data-memory wait.
- It drives PC/ID hold, EX bubble insertion, MEM freeze and ID flush.
- It owns the mul/div occupancy counter and a stall-cycle statistics counter.

---
 rtl/hazard_ctl_if.sv | 35 +++
 rtl/hazard_ctl.sv | 102 ++++++++++
 tb/tb_hazard_ctl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_if.sv
// Pipeline-side view of the interlock controller: hazard inputs from ID/EX/MEM, advance controls back.
// The controller is combinational on these signals, except muldiv_busy and stall_cnt, which are registered.
interface hazard_ctl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs_rn;
  logic             id_rs_use;
  logic [4:0]       id_rt_rn;
  logic             id_rt_use;
  logic             ex_load;
  logic [4:0]       ex_wr_rn;
  logic             id_muldiv_start;
  logic             id_hilo_read;
  logic             dmem_wait;
  logic             flush_req;
  logic             pc_hold;
  logic             id_hold;
  logic             ex_bubble;
  logic             mem_hold;
  logic             id_flush;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs_rn, id_rs_use, id_rt_rn, id_rt_use, ex_load, ex_wr_rn,
           id_muldiv_start, id_hilo_read, dmem_wait, flush_req,
    input  pc_hold, id_hold, ex_bubble, mem_hold, id_flush, muldiv_busy, stall_cnt
  );

  modport slave (
    input  id_rs_rn, id_rs_use, id_rt_rn, id_rt_use, ex_load, ex_wr_rn,
           id_muldiv_start, id_hilo_read, dmem_wait, flush_req,
    output pc_hold, id_hold, ex_bubble, mem_hold, id_flush, muldiv_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctl.sv
// Pipeline interlock: same-cycle hold/bubble/flush decisions, mul/div occupancy tracking, stall statistics.
// Outputs are combinational (0-cycle latency); dmem_wait freezes everything and outranks flush and interlocks.
module hazard_ctl #(
  parameter int MULDIV_CYCLES = 33,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctl_if.slave bus
);
  localparam int MD_W = $clog2(MULDIV_CYCLES);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t        md_state;
  logic [MD_W-1:0]  md_cnt;
  logic [CNT_W-1:0] stall_q;

  logic lu;
  logic md;
  logic busy;
  logic pc_hold;
  logic id_hold;
  logic ex_bubble;
  logic mem_hold;
  logic id_flush;
  logic start_ok;

  assign busy = (md_state == MD_BUSY);

  // A load writing r0 never produces data, so it cannot create a dependence.
  assign lu = bus.ex_load && (bus.ex_wr_rn != 5'd0) &&
              ((bus.id_rs_use && (bus.id_rs_rn == bus.ex_wr_rn)) ||
               (bus.id_rt_use && (bus.id_rt_rn == bus.ex_wr_rn)));
  assign md = busy && (bus.id_hilo_read || bus.id_muldiv_start);

  always_comb begin
    pc_hold   = 1'b0;
    id_hold   = 1'b0;
    ex_bubble = 1'b0;
    mem_hold  = 1'b0;
    id_flush  = 1'b0;
    if (rst) begin
      if (bus.dmem_wait) begin
        pc_hold  = 1'b1;
        id_hold  = 1'b1;
        mem_hold = 1'b1;
      end else if (bus.flush_req) begin
        id_flush = 1'b1;
      end else if (lu || md) begin
        pc_hold   = 1'b1;
        id_hold   = 1'b1;
        ex_bubble = 1'b1;
      end
    end
  end

  // An issue only counts when the mul/div instruction actually leaves ID this cycle.
  assign start_ok = (md_state == MD_IDLE) && bus.id_muldiv_start &&
                    !(pc_hold || id_hold || ex_bubble || mem_hold || id_flush);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      stall_q  <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (start_ok) begin
            md_state <= MD_BUSY;
            md_cnt   <= MD_W'(MULDIV_CYCLES - 1);
          end
        end
        MD_BUSY: begin
          // The unit runs free of the pipeline: no freeze or flush pauses the countdown.
          if (md_cnt == '0) begin
            md_state <= MD_IDLE;
          end else begin
            md_cnt <= md_cnt - 1'b1;
          end
        end
        default: begin
          md_state <= MD_IDLE;
          md_cnt   <= '0;
        end
      endcase

      if (pc_hold && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.pc_hold     = pc_hold;
  assign bus.id_hold     = id_hold;
  assign bus.ex_bubble   = ex_bubble;
  assign bus.mem_hold    = mem_hold;
  assign bus.id_flush    = id_flush;
  assign bus.muldiv_busy = busy;
  assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: inputs change 1 ns after the rising edge, outputs are sampled 3 ns after it.
module tb_hazard_ctl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   base;

  hazard_ctl_if #(.CNT_W(16)) bus ();

  hazard_ctl #(.MULDIV_CYCLES(33), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.id_rs_rn        = 5'd0;
    bus.id_rs_use       = 1'b0;
    bus.id_rt_rn        = 5'd0;
    bus.id_rt_use       = 1'b0;
    bus.ex_load         = 1'b0;
    bus.ex_wr_rn        = 5'd0;
    bus.id_muldiv_start = 1'b0;
    bus.id_hilo_read    = 1'b0;
    bus.dmem_wait       = 1'b0;
    bus.flush_req       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk({tag, ".ctl"}, {27'd0, bus.pc_hold, bus.id_hold, bus.ex_bubble, bus.mem_hold, bus.id_flush},
        {27'd0, exp});
  endtask

  task automatic set_lu_rs(input logic [4:0] rn);
    bus.ex_load   = 1'b1;
    bus.ex_wr_rn  = rn;
    bus.id_rs_use = 1'b1;
    bus.id_rs_rn  = rn;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    // Reset: hostile inputs must not reach the outputs
    bus.dmem_wait = 1'b1;
    bus.flush_req = 1'b1;
    set_lu_rs(5'd5);
    #3;
    chk_ctl("reset", 5'b00000);
    chk("reset.busy", {31'd0, bus.muldiv_busy}, 0);
    chk("reset.cnt", {16'd0, bus.stall_cnt}, 0);
    next_cycle();
    idle_inputs();
    rst = 1'b1;

    // Load-use on rs: one stall cycle
    next_cycle();
    set_lu_rs(5'd5);
    settle();
    chk_ctl("lu_rs", 5'b11100);
    next_cycle();
    bus.ex_load = 1'b0;
    settle();
    chk_ctl("lu_rs.after", 5'b00000);
    chk("lu_rs.cnt", {16'd0, bus.stall_cnt}, 1);

    // rt match only counts when rt is actually read
    next_cycle();
    idle_inputs();
    bus.ex_load  = 1'b1;
    bus.ex_wr_rn = 5'd9;
    bus.id_rt_rn = 5'd9;
    settle();
    chk_ctl("lu_rt.unused", 5'b00000);
    bus.id_rt_use = 1'b1;
    #1;
    chk_ctl("lu_rt", 5'b11100);

    // Load to r0
    next_cycle();
    idle_inputs();
    set_lu_rs(5'd0);
    settle();
    chk_ctl("lu_r0", 5'b00000);
    chk("lu_r0.cnt", {16'd0, bus.stall_cnt}, 2);

    // Start under dmem_wait is not accepted
    next_cycle();
    idle_inputs();
    bus.id_muldiv_start = 1'b1;
    bus.dmem_wait       = 1'b1;
    settle();
    chk_ctl("md_blocked", 5'b11010);
    next_cycle();
    idle_inputs();
    settle();
    chk("md_blocked.busy", {31'd0, bus.muldiv_busy}, 0);
    chk("md_blocked.cnt", {16'd0, bus.stall_cnt}, 3);

    // Mul/div occupancy: start at T, mflo waits T+1..T+33
    base = 3;
    next_cycle();
    bus.id_muldiv_start = 1'b1;
    settle();
    chk_ctl("md_issue", 5'b00000);
    for (int i = 1; i <= 33; i++) begin
      next_cycle();
      idle_inputs();
      bus.id_hilo_read = 1'b1;
      settle();
      chk("md_busy", {31'd0, bus.muldiv_busy}, 1);
      chk_ctl("md_stall", 5'b11100);
    end
    next_cycle();
    settle();
    chk("md_release.busy", {31'd0, bus.muldiv_busy}, 0);
    chk_ctl("md_release", 5'b00000);
    chk("md_release.cnt", {16'd0, bus.stall_cnt}, base + 33);

    // Priority: freeze beats flush and load-use, then flush beats load-use
    next_cycle();
    idle_inputs();
    set_lu_rs(5'd7);
    bus.dmem_wait = 1'b1;
    bus.flush_req = 1'b1;
    settle();
    chk_ctl("prio.freeze", 5'b11010);
    next_cycle();
    bus.dmem_wait = 1'b0;
    settle();
    chk_ctl("prio.flush", 5'b00001);
    chk("prio.cnt", {16'd0, bus.stall_cnt}, base + 34);

    // Flush does not cancel an occupancy
    next_cycle();
    idle_inputs();
    bus.id_muldiv_start = 1'b1;
    next_cycle();
    idle_inputs();
    bus.flush_req = 1'b1;
    settle();
    chk("flush_md.busy", {31'd0, bus.muldiv_busy}, 1);

    // Asynchronous reset in the middle of an occupancy
    for (int i = 2; i <= 10; i++) begin
      next_cycle();
      idle_inputs();
      bus.id_hilo_read = 1'b1;
    end
    settle();
    chk("prerst.busy", {31'd0, bus.muldiv_busy}, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid.busy", {31'd0, bus.muldiv_busy}, 0);
    chk("rst_mid.cnt", {16'd0, bus.stall_cnt}, 0);
    chk_ctl("rst_mid", 5'b00000);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    settle();
    chk_ctl("post_rst.mflo", 5'b00000);
    chk("post_rst.busy", {31'd0, bus.muldiv_busy}, 0);

    // Saturation after 65540 consecutive stall cycles
    next_cycle();
    idle_inputs();
    set_lu_rs(5'd3);
    for (int i = 0; i < 65540; i++) begin
      next_cycle();
    end
    settle();
    chk_ctl("sat.stall", 5'b11100);
    chk("sat.cnt", {16'd0, bus.stall_cnt}, 65535);
    next_cycle();
    settle();
    chk("sat.hold", {16'd0, bus.stall_cnt}, 65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
